stopwatch_timer: RTL
====================

Name: stopwatch_timer

Overview:
- Consumes the one-cycle tick pulses produced by the clock-divider chain. One pulse is one hundredth of a second.
- Accumulates elapsed time in BCD as MM:SS.hh under start/stop, clear and lap controls.
- Feeds the display multiplexer with a six-digit BCD word. This block is the tick consumer at the far end of the divider chain.
- All logic runs in the single system clock domain. It uses the tick as an enable and never as a clock.

Parameters:
- MAX_MIN, 59, highest minute value before wrap (range 1..99).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle enable pulse, nominally 100 Hz
- start_stop  in  1  one-cycle pulse, debounced upstream
- clear  in  1  one-cycle pulse, debounced upstream
- lap  in  1  one-cycle pulse, debounced upstream
- time_bcd  out  24  live count {min_t, min_o, sec_t, sec_o, hs_t, hs_o}, 4 bits each
- disp_bcd  out  24  display value: time_bcd, or frozen lap value while lap_active
- running  out  1  high in RUN state
- lap_active  out  1  lap freeze in effect
- overflow  out  1  sticky flag: count wrapped past MAX_MIN:59.99

Behaviour:
- All outputs are registered.
- Reset: synchronous on rst=1 at a clk edge.
  - State goes to IDLE.
  - time_bcd and disp_bcd go to 0.
  - running, lap_active and overflow go to 0.
  - rst has priority over every other input.
  - rst mid-run discards the count immediately.
- States:
  - IDLE: count is zero.
  - RUN: counting.
  - STOP: paused, count held.
- Transitions on start_stop:
  - IDLE→RUN
  - RUN→STOP
  - STOP→RUN
- Transitions on clear:
  - From any state to IDLE.
  - clear zeroes the count, clears overflow and clears lap_active.
- Input priority in the same cycle: rst > clear > start_stop > lap.
- Tick handling:
  - A tick is applied only if the registered state is RUN in that cycle, i.e. the state before any transition in the same cycle.
  - tick together with start_stop in RUN: the tick is counted, then the state goes to STOP.
  - tick together with start_stop in STOP: the tick is ignored.
  - tick together with clear: the tick is ignored and the count becomes 0.
- Latency: time_bcd updates on the clk edge that samples tick=1 and is visible from the next cycle. The same applies to running.
- Counting is a cascaded BCD chain. Each digit rolls over and carries to the next:
  - hs_o: 0..9
  - hs_t: 0..9
  - sec_o: 0..9
  - sec_t: 0..5
  - min_o / min_t: together count 00..MAX_MIN as BCD
- Wrap: a tick at MAX_MIN:59.99 produces 00:00.00 and sets overflow=1. Counting continues, and overflow holds until clear or rst.
- No digit may ever hold a value above 9. sec_t may never exceed 5.
- Lap:
  - Accepted only in RUN.
  - lap with lap_active=0: capture the time_bcd value after this cycle's tick into the hold register, and set lap_active=1.
  - lap with lap_active=1: release the hold and set lap_active=0.
  - lap in IDLE or STOP is ignored.
  - RUN→STOP forces lap_active=0, so the display shows the final time.
- disp_bcd = lap_active ? hold register : time_bcd. It is registered with the same one-cycle latency as time_bcd.
- tick pulses longer than one cycle are out of contract. Each high cycle counts as a separate tick.

Test Plan:
- Reset, start_stop, then 123 ticks -> time_bcd = 0x000123 (00:01.23), running=1, disp_bcd = time_bcd.
- Run to 00:59.99, then one tick -> 0x010000. From 09:59.99, one tick -> 0x100000.
- MAX_MIN=59 at 59:59.99, one tick -> time_bcd=0, overflow=1. Further ticks keep counting. clear -> overflow=0, IDLE.
- Running at 00:00.50: lap, then 25 ticks -> disp_bcd = 0x000050 while time_bcd = 0x000075. lap again -> disp_bcd = 0x000075 one cycle later.
- Simultaneous events:
  - tick+start_stop in RUN at 0x000010 -> 0x000011, state STOP.
  - tick+start_stop in STOP -> stays 0x000011, state RUN.
  - tick+clear -> 0, IDLE.
- rst asserted mid-run at 0x012345 with tick high -> next cycle all outputs 0, IDLE. lap and tick in IDLE are ignored.

Source files
------------

// File: rtl/stopwatch_timer.sv
// Stopwatch counting hundredths of a second in BCD (MM:SS.hh) from a tick enable,
// with start/stop, clear and lap-freeze controls. All outputs are registered.
module stopwatch_timer #(
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] time_bcd,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

    state_t      state_reg;
    logic [23:0] time_reg;
    logic [23:0] disp_reg;
    logic [23:0] hold_reg;
    logic        running_reg;
    logic        lap_active_reg;
    logic        overflow_reg;

    logic        tick_en;
    logic [4:0]  carry;
    logic [23:0] count_inc;
    logic [3:0]  min_t_inc;
    logic [3:0]  min_o_inc;
    logic        wrap;

    logic [23:0] time_next;
    logic [23:0] hold_next;
    logic        lap_next;
    logic        overflow_next;

    // Only the registered state gates the tick, so a same-cycle start_stop
    // in RUN still counts this tick while one in STOP does not.
    assign tick_en  = tick && (state_reg == RUN);
    assign carry[0] = tick_en;

    // Lower four digits: hs_o, hs_t, sec_o (0..9) and sec_t (0..5).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 3) ? 4'd5 : 4'd9;
            logic [3:0] digit;
            assign digit = time_reg[4*gi +: 4];
            assign count_inc[4*gi +: 4] = carry[gi] ? ((digit >= LIM) ? 4'd0 : digit + 4'd1)
                                                    : digit;
            assign carry[gi+1] = carry[gi] && (digit >= LIM);
        end
    endgenerate

    // Minutes count as a two-digit BCD pair up to MAX_MIN, then wrap the whole count.
    always_comb begin
        min_t_inc = time_reg[23:20];
        min_o_inc = time_reg[19:16];
        wrap      = 1'b0;
        if (carry[4]) begin
            if ((time_reg[23:20] == MAX_T) && (time_reg[19:16] == MAX_O)) begin
                min_t_inc = 4'd0;
                min_o_inc = 4'd0;
                wrap      = 1'b1;
            end else if (time_reg[19:16] >= 4'd9) begin
                min_o_inc = 4'd0;
                min_t_inc = time_reg[23:20] + 4'd1;
            end else begin
                min_o_inc = time_reg[19:16] + 4'd1;
            end
        end
    end

    assign count_inc[23:16] = {min_t_inc, min_o_inc};

    always_comb begin
        time_next     = count_inc;
        overflow_next = overflow_reg | wrap;
        lap_next      = lap_active_reg;
        hold_next     = hold_reg;
        if (clear) begin
            time_next     = 24'd0;
            overflow_next = 1'b0;
            lap_next      = 1'b0;
        end else if (state_reg == RUN) begin
            if (start_stop) begin
                lap_next = 1'b0;
            end else if (lap) begin
                if (lap_active_reg) begin
                    lap_next = 1'b0;
                end else begin
                    lap_next  = 1'b1;
                    hold_next = count_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            time_reg       <= 24'd0;
            disp_reg       <= 24'd0;
            hold_reg       <= 24'd0;
            running_reg    <= 1'b0;
            lap_active_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            time_reg       <= time_next;
            hold_reg       <= hold_next;
            lap_active_reg <= lap_next;
            overflow_reg   <= overflow_next;
            disp_reg       <= lap_next ? hold_next : time_next;
            if (clear) begin
                state_reg   <= IDLE;
                running_reg <= 1'b0;
            end else if (start_stop) begin
                case (state_reg)
                    IDLE, STOP: begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                    RUN: begin
                        state_reg   <= STOP;
                        running_reg <= 1'b0;
                    end
                    default: begin
                        state_reg   <= IDLE;
                        running_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign time_bcd   = time_reg;
    assign disp_bcd   = disp_reg;
    assign running    = running_reg;
    assign lap_active = lap_active_reg;
    assign overflow   = overflow_reg;

endmodule
